iter_muldiv: RTL and testbench

Iterative 8-bit multiply/divide engine for the ALU. It runs a radix-2 Booth signed multiply or a non-restoring unsigned divide, one iteration per clock. It keeps its own 3-bit iteration counter and next-state logic. It presents a start/busy/done handshake to the ALU top, which launches the operation and collects the 16-bit result.

---
 rtl/iter_muldiv.sv | 99 +++++++++
 tb/tb_iter_muldiv.sv | 113 +++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative 8-bit Booth signed multiply / non-restoring unsigned divide (divide built only with ITER_MULDIV_DIV_EN)
module iter_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_by_zero
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [8:0] acc, m, bsum, mul_acc;
  logic [7:0] q, mul_q;
  logic q_1, last;
  assign last = cnt == 3'd7;
  assign bsum = (q[0] & ~q_1) ? acc - m : (~q[0] & q_1) ? acc + m : acc;
  assign mul_acc = {bsum[8], bsum[8:1]};
  assign mul_q = {bsum[0], q[7:1]};
`ifdef ITER_MULDIV_DIV_EN
  logic [8:0] dsh, dacc, fix;
  logic [7:0] dq;
  assign dsh = {acc[7:0], q[7]};
  assign dacc = acc[8] ? dsh + m : dsh - m;
  assign dq = {q[6:0], ~dacc[8]};
  assign fix = acc[8] ? acc + m : acc;
`endif
  // state register
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state logic
  always_comb begin
    state_n = IDLE;
    case (state)
`ifdef ITER_MULDIV_DIV_EN
      IDLE: state_n = !start ? IDLE : !op ? MUL : (b != 8'd0) ? DIV : DONE;
      DIV:  state_n = last ? FIX : DIV;
      FIX:  state_n = DONE;
`else
      IDLE: state_n = !start ? IDLE : !op ? MUL : DONE;
`endif
      MUL:  state_n = last ? DONE : MUL;
      default: state_n = IDLE;
    endcase
  end
  // handshake outputs
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // datapath: operand capture, iteration steps and result write-back
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      m <= '0;
      q <= '0;
      q_1 <= 1'b0;
      result <= '0;
      div_by_zero <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          acc <= '0;
          q_1 <= 1'b0;
          q <= op ? a : b;
          m <= op ? {1'b0, b} : {a[7], a};
`ifdef ITER_MULDIV_DIV_EN
          div_by_zero <= op && b == 8'd0;
          if (op && b == 8'd0) result <= {a, 8'hFF};
`else
          div_by_zero <= 1'b0;
          if (op) result <= '0;
`endif
        end
        MUL: begin
          acc <= mul_acc;
          q <= mul_q;
          q_1 <= q[0];
          cnt <= cnt + 3'd1;
          if (last) result <= {mul_acc[7:0], mul_q};
        end
`ifdef ITER_MULDIV_DIV_EN
        DIV: begin
          acc <= dacc;
          q <= dq;
          cnt <= cnt + 3'd1;
        end
        FIX: result <= {fix[7:0], q};
`endif
        default: ;
      endcase
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: directed self-checking bench for iter_muldiv
module tb_iter_muldiv;
  logic clk = 0, rst = 0, start = 0, op = 0;
  logic [7:0] a = 0, b = 0;
  logic busy, done, div_by_zero;
  logic [15:0] result;
  int n_cmp = 0, n_err = 0;

  iter_muldiv dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                   .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(string tag, logic o, logic [7:0] x, logic [7:0] y, int lat, logic [15:0] r, logic z);
    int k = -1;
    op = o; a = x; b = y; start = 1;
    tick();
    start = 0; a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
    check({tag, "_busy_hi"}, 32'(busy), 32'd1);
    for (int i = 0; i <= 20; i++) begin
      if (done) begin k = i; break; end
      tick();
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
    tick();
    check({tag, "_done_lo"}, 32'(done), 32'd0);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nd, kf;
    logic rop;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1;
    tick();
    run_op("mul_7_m3", 0, 8'd7, 8'hFD, 8, 16'hFFEB, 0);
    run_op("mul_m128_m128", 0, 8'h80, 8'h80, 8, 16'h4000, 0);
    run_op("mul_m128_1", 0, 8'h80, 8'h01, 8, 16'hFF80, 0);
`ifdef ITER_MULDIV_DIV_EN
    run_op("div_200_7", 1, 8'd200, 8'd7, 9, 16'h041C, 0);
    run_op("div_5_0", 1, 8'd5, 8'd0, 0, 16'h05FF, 1);
    rop = 1;
`else
    run_op("div_off_200_7", 1, 8'd200, 8'd7, 0, 16'h0000, 0);
    run_op("div_off_5_0", 1, 8'd5, 8'd0, 0, 16'h0000, 0);
    rop = 0;
`endif
    run_op("mul_m1_m1", 0, 8'hFF, 8'hFF, 8, 16'h0001, 0);
    // start re-pulsed at E3 must be ignored
    op = 0; a = 8'd12; b = 8'd11; start = 1;
    tick();
    start = 0;
    tick(); tick();
    start = 1; op = 1; a = 8'd3; b = 8'd3;
    tick();
    start = 0;
    nd = 0; kf = -1;
    for (int i = 3; i <= 25; i++) begin
      if (done) begin nd++; if (kf < 0) kf = i; end
      if (!busy) break;
      tick();
    end
    check("ignore_done_cnt", nd, 1);
    check("ignore_latency", kf, 8);
    check("ignore_result", 32'(result), 32'h0084);
    check("ignore_busy_lo", 32'(busy), 32'd0);
    // reset at E4 of an in-flight operation
    op = rop; a = 8'd100; b = 8'd3; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    rst = 0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    check("midrst_no_done", nd, 0);
`ifdef ITER_MULDIV_DIV_EN
    run_op("div_255_16", 1, 8'd255, 8'd16, 9, 16'h0F0F, 0);
`else
    run_op("div_off_255_16", 1, 8'd255, 8'd16, 0, 16'h0000, 0);
`endif
    run_op("mul_after_rst", 0, 8'd15, 8'd17, 8, 16'h00FF, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
